// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and defaults for the decode-stage hazard/stall controller.
package hazard_stall_unit_pkg;

  localparam int TNEW_W = 3;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2
  } md_op_e;

  function automatic md_op_e md_class(input logic start, input logic is_div);
    if (!start)  return MD_NONE;
    if (is_div)  return MD_DIV;
    return MD_MULT;
  endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_tracker.sv
// Multiply/divide unit busy countdown: cancel beats issue, issue beats decrement.
module md_busy_tracker
  import hazard_stall_unit_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   cancel,
  input  logic   issue,
  input  md_op_e op,
  output logic   busy
);

  localparam int CNTW = $clog2(DIV_LAT + 1);

  logic [CNTW-1:0] count;
  logic [CNTW-1:0] count_next;

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    count_next = count;
    if (cancel)
      count_next = '0;
    else if (issue)
      count_next = (op == MD_DIV) ? CNTW'(DIV_LAT) : CNTW'(MULT_LAT);
    else if (count != '0)
      count_next = count - CNTW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else
      count <= count_next;
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// RAW-hazard and MD-busy stall generation for the decode stage, with
// saturating stall-cycle counters.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int NSTG     = 2,
  parameter int NRP      = 2,
  parameter int TW       = TNEW_W,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CW       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              D_valid,
  input  logic [NRP*5-1:0]  D_ra,
  input  logic [NRP*TW-1:0] D_tuse,
  input  logic [NSTG*5-1:0] S_wa,
  input  logic [NSTG*TW-1:0] S_tnew,
  input  logic              D_md_use,
  input  logic              D_md_start,
  input  logic              D_md_div,
  input  logic              md_cancel,
  output logic              stall,
  output logic              md_busy,
  output logic [CW-1:0]     cnt_data,
  output logic [CW-1:0]     cnt_md
);

  logic [NRP*NSTG-1:0] hit;
  logic                data_hz;
  logic                md_hz;
  logic                issue;

  // One comparator per (read port, later stage); $0 never carries a dependency.
  for (genvar p = 0; p < NRP; p++) begin : g_port
    for (genvar s = 0; s < NSTG; s++) begin : g_stage
      assign hit[p*NSTG+s] = (D_ra[p*5 +: 5] != 5'd0)
                          && (D_ra[p*5 +: 5] == S_wa[s*5 +: 5])
                          && (D_tuse[p*TW +: TW] < S_tnew[s*TW +: TW]);
    end
  end

  assign data_hz = D_valid & (|hit);
  assign md_hz   = D_valid & D_md_use & md_busy;
  assign stall   = data_hz | md_hz;
  assign issue   = D_valid & D_md_start & ~stall;

  md_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_md_busy_tracker (
    .clk    (clk),
    .reset  (reset),
    .cancel (md_cancel),
    .issue  (issue),
    .op     (md_class(D_md_start, D_md_div)),
    .busy   (md_busy)
  );

  // Counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_data <= '0;
      cnt_md   <= '0;
    end else begin
      if (data_hz && (cnt_data != '1))
        cnt_data <= cnt_data + CW'(1);
      if (md_hz && !data_hz && (cnt_md != '1))
        cnt_md <= cnt_md + CW'(1);
    end
  end

endmodule
